tile_fetch_ctrl: RTL and testbench
==================================

# tile_fetch_ctrl

Sequencer for the operand-fetch side of the systolic tensor core. On a start command it drives the single A-side and B-side address-generator units (which then propagate systolically): read enables, buffer read addresses, sub-word element index, accumulator-init flag and double-buffer select. The read cadence follows the precision mode, and the controller holds a drain window for array skew before reporting completion.

## Interface
- `ARRAY_N`, default 4: systolic array dimension; drain length is 2*ARRAY_N-1 cycles.
- `AW`, default 4: buffer address width; maximum tile length is 2^AW words.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: tile request; sampled only in IDLE.
- `mode` in 2: precision, latched on accepted start. 0=FP32, 1=FP16, 2=INT8, 3=INT4.
- `words` in AW+1: tile length in 32-bit words, 0..2^AW; latched on accepted start.
- `stall` in 1: downstream back-pressure; freezes FETCH progress.
- `en_a`, `en_b` out 1: fetch-enable pulses to the A/B addrgen units.
- `cin_en` out 1: first-element flag (accumulator init) to the B unit.
- `rdaddr` out AW: word address for the current fetch.
- `sub_idx` out 3: element index within the current word.
- `sel` out 1: double-buffer select; the bank being read.
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- Repeat factor R per mode: FP32=1, FP16=2, INT8=4, INT4=8. This is the number of elements per word. The address advances once every R fetch cycles. `sub_idx` counts 0..R-1 within each word.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE
  - `start`=1 and `words`>0 → FETCH; latch `mode` and `words`; clear counters.
  - `start`=1 and `words`=0 → DONE directly. No enables, and `sel` does not toggle.
- FETCH
  - Each non-stalled cycle: `en_a`=`en_b`=1, presenting (`rdaddr`, `sub_idx`).
  - `sub_idx` increments. When `sub_idx`=R-1, it wraps to 0 and `rdaddr` increments.
  - After the fetch with `rdaddr`=`words`-1 and `sub_idx`=R-1, go to DRAIN.
  - `cin_en`=1 only on the fetch with `rdaddr`=0 and `sub_idx`=0.
- Stall in FETCH: `en_a`/`en_b`/`cin_en`=0; `rdaddr`/`sub_idx` hold; no state change. Stall is ignored in all other states.
- DRAIN: exactly 2*ARRAY_N-1 cycles, counted by a drain counter. Then go to DONE.
- DONE: `done`=1 for one cycle. `sel` toggles on the DONE→IDLE edge only if at least one word was fetched. Then go to IDLE.
- `start` outside IDLE is ignored and not queued.
- Full tile: with `words`=2^AW, the last `rdaddr` is 2^AW-1. The address wraps to 0 internally but is never presented.

## Timing
- All outputs are registered.
- Reset values: FSM=IDLE, `en_a`=`en_b`=`cin_en`=0, `rdaddr`=0, `sub_idx`=0, `sel`=0, `busy`=0, `done`=0.
- `start` accepted at edge t:
  - First fetch (`en_a`=1) is visible in cycle t+1.
  - FETCH lasts `words`*R cycles plus stall cycles.
  - DRAIN lasts 2*ARRAY_N-1 cycles.
  - `done` follows in the next cycle.
- `start` with `words`=0: `done` in cycle t+1 and `busy`=1 for one cycle.
- Reset asserted mid-tile: immediate return to reset values, including `sel`=0. No `done` is issued.
- Ready for a new `start` in the cycle after `done`. Back-to-back tiles alternate `sel`.

## Structure
- Shared package `params`:
  - precision enum `prec_t` (FP32/FP16/INT8/INT4);
  - FSM enum `fetch_state_t`;
  - function `rep_factor(prec_t)` returning R;
  - constant for drain length derived from ARRAY_N.
- One natural sub-module: `fetch_counter`, the (`rdaddr`, `sub_idx`) counter with enable, R-wrap and last-flag. The FSM and drain counter live in the top module.

## Test plan
- FP32, `words`=4, ARRAY_N=4, start at edge 0:
  - `rdaddr`=0,1,2,3 in cycles 1–4; `sub_idx`=0 throughout; `cin_en` only in cycle 1.
  - DRAIN in cycles 5–11; `done` in cycle 12; `sel` reads 1 afterwards.
- FP16, `words`=2: (`rdaddr`,`sub_idx`)=(0,0),(0,1),(1,0),(1,1) over 4 cycles. `done` 12 cycles after the first fetch (4 fetch + 7 drain + 1).
- INT4, `words`=1: 8 fetches with `rdaddr`=0 and `sub_idx` 0..7. Run a second tile back-to-back → `sel` returns to 0.
- Stall during INT8, `words`=2: `stall`=1 for 3 cycles at (0,2).
  - Enables low and outputs hold at (0,2) for those 3 cycles.
  - Resumes at (0,2); total FETCH is 11 cycles.
- `words`=0: `done` at t+1, no enables, `sel` unchanged. A `start` pulsed during FETCH/DRAIN is ignored: exactly one `done` per accepted start.
- `rst` low mid-FETCH at (1,0): all outputs return to reset values asynchronously. After release, a new `start` begins at `rdaddr`=0 with `sel`=0.

Source files
------------

// File: rtl/tile_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tile_fetch_ctrl_pkg
// Description : Shared types and helpers for the tensor-core operand-fetch
//               sequencer: precision modes, FSM states, repeat factor and
//               drain length.
// Revision    : 1.0 - initial release
// ============================================================================
package tile_fetch_ctrl_pkg;

  // Precision of the operands; encoding matches the mode input pins
  typedef enum logic [1:0] {
    PREC_FP32 = 2'd0,
    PREC_FP16 = 2'd1,
    PREC_INT8 = 2'd2,
    PREC_INT4 = 2'd3
  } prec_t;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

  // Elements packed in one 32-bit word for a given precision
  function automatic logic [3:0] rep_factor(input prec_t p);
    logic [3:0] r;
    r = 4'd1;
    case (p)
      PREC_FP32: r = 4'd1;
      PREC_FP16: r = 4'd2;
      PREC_INT8: r = 4'd4;
      PREC_INT4: r = 4'd8;
      default:   r = 4'd1;
    endcase
    return r;
  endfunction

  // Cycles needed for the last operands to ripple through the array skew
  function automatic int drain_len(input int array_n);
    return 2 * array_n - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tile_fetch_ctrl_fetch_counter.sv
`default_nettype none
// ============================================================================
// Module      : tile_fetch_ctrl_fetch_counter
// Description : Word address / sub-word element counter. The element index
//               wraps at the repeat factor and carries into the address;
//               flags the final element of the tile.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_fetch_ctrl_fetch_counter #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,      // asynchronous, active low
  input  logic          clear,
  input  logic          advance,
  input  logic [3:0]    rep,
  input  logic [AW:0]   words,
  output logic [AW-1:0] addr,
  output logic [2:0]    sub,
  output logic          last
);

  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    sub_q, sub_d;
  logic          w_wrap;
  logic [AW:0]   w_addr_p1;

  // Last element of a word, and last word of the tile (address+1 == length)
  assign w_wrap    = ({1'b0, sub_q} == (rep - 4'd1));
  assign w_addr_p1 = {1'b0, addr_q} + (AW+1)'(1);
  assign last      = w_wrap && (w_addr_p1 == words);

  // Next counter value: clear wins, otherwise step with carry into address
  always_comb begin
    addr_d = addr_q;
    sub_d  = sub_q;
    if (clear) begin
      addr_d = '0;
      sub_d  = '0;
    end else if (advance) begin
      if (w_wrap) begin
        sub_d  = '0;
        addr_d = addr_q + AW'(1);
      end else begin
        sub_d  = sub_q + 3'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      sub_q  <= '0;
    end else begin
      addr_q <= addr_d;
      sub_q  <= sub_d;
    end
  end

  assign addr = addr_q;
  assign sub  = sub_q;

endmodule
`default_nettype wire

// File: rtl/tile_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tile_fetch_ctrl
// Description : Operand-fetch sequencer for the systolic tensor core. Issues
//               A/B fetch enables with word address and element index at the
//               precision-dependent cadence, waits out the array skew, then
//               pulses done and flips the double-buffer select.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_fetch_ctrl
  import tile_fetch_ctrl_pkg::*;
#(
  parameter int ARRAY_N = 4,
  parameter int AW      = 4
) (
  input  logic          clk,
  input  logic          rst,      // asynchronous, active low
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [AW:0]   words,
  input  logic          stall,
  output logic          en_a,
  output logic          en_b,
  output logic          cin_en,
  output logic [AW-1:0] rdaddr,
  output logic [2:0]    sub_idx,
  output logic          sel,
  output logic          busy,
  output logic          done
);

  localparam int c_drain_len = drain_len(ARRAY_N);
  localparam int c_drain_w   = $clog2(c_drain_len + 1);

  fetch_state_t         state_q, state_d;
  prec_t                mode_q, mode_d;
  logic [AW:0]          words_q, words_d;
  logic [c_drain_w-1:0] drain_q, drain_d;
  logic                 en_q, en_d;
  logic                 cin_en_q, cin_en_d;
  logic                 sel_q, sel_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 w_accept;
  logic                 w_fetch_fire;
  logic                 w_cnt_last;
  logic [3:0]           w_rep;

  assign w_rep        = rep_factor(mode_q);
  assign w_accept     = (state_q == ST_IDLE) && start;
  // The element shown this cycle is actually being fetched
  assign w_fetch_fire = (state_q == ST_FETCH) && en_q;

  // Counter steps past each fetched element; it stops on the final one so
  // the wrapped address never appears on rdaddr
  tile_fetch_ctrl_fetch_counter #(
    .AW (AW)
  ) u_fetch_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_accept),
    .advance (w_fetch_fire && !w_cnt_last),
    .rep     (w_rep),
    .words   (words_q),
    .addr    (rdaddr),
    .sub     (sub_idx),
    .last    (w_cnt_last)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (words == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH: if (w_fetch_fire && w_cnt_last) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q == c_drain_w'(c_drain_len - 1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and tile context
  always_comb begin
    mode_d   = mode_q;
    words_d  = words_q;
    en_d     = 1'b0;
    cin_en_d = 1'b0;
    drain_d  = (state_q == ST_DRAIN) ? drain_q + c_drain_w'(1) : '0;
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
    // Empty tiles never touched the bank, so the select stays put
    sel_d    = sel_q ^ ((state_q == ST_DONE) && (words_q != '0));
    if (w_accept) begin
      mode_d   = prec_t'(mode);
      words_d  = words;
      // First fetch always goes out the cycle after acceptance
      en_d     = (words != '0);
      cin_en_d = (words != '0);
    end else if (state_q == ST_FETCH) begin
      en_d     = !(w_fetch_fire && w_cnt_last) && !stall;
    end
  end

  // Output and context registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= PREC_FP32;
      words_q  <= '0;
      drain_q  <= '0;
      en_q     <= 1'b0;
      cin_en_q <= 1'b0;
      sel_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      words_q  <= words_d;
      drain_q  <= drain_d;
      en_q     <= en_d;
      cin_en_q <= cin_en_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign en_a   = en_q;
  assign en_b   = en_q;
  assign cin_en = cin_en_q;
  assign sel    = sel_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tile_fetch_ctrl
// Description : Self-checking bench for tile_fetch_ctrl: per-cycle compare
//               against a cycle-count model plus literal tile expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_fetch_ctrl;

  localparam int ARRAY_N = 4;
  localparam int AW      = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [AW:0]   words = '0;
  logic          stall = 1'b0;
  logic          en_a, en_b, cin_en, sel, busy, done;
  logic [AW-1:0] rdaddr;
  logic [2:0]    sub_idx;

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;
  logic chk_en = 1'b0;

  tile_fetch_ctrl #(.ARRAY_N(ARRAY_N), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .words(words),
    .stall(stall), .en_a(en_a), .en_b(en_b), .cin_en(cin_en),
    .rdaddr(rdaddr), .sub_idx(sub_idx), .sel(sel), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A tile is a list of W*R elements, then a fixed drain, then one done
  // cycle; stalls only delay elements that are not the first.
  int   m_busy, m_w, m_r, m_k, m_fl, m_dl, m_dn, m_first;
  logic m_sel;
  logic e_en, e_cin, e_done, e_busy, e_av;
  int   e_addr, e_sub;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_fl = 0; m_dl = 0; m_dn = 0; m_sel = 1'b0;
      e_en = 0; e_cin = 0; e_done = 0; e_busy = 0; e_av = 1; e_addr = 0; e_sub = 0;
    end else begin
      e_en = 0; e_cin = 0; e_done = 0;
      if (m_busy == 0) begin
        if (start) begin
          m_busy = 1; m_w = int'(words); m_r = 1 << mode; m_k = 0;
          m_fl = m_w * m_r; m_dl = (m_w != 0) ? 2 * ARRAY_N - 1 : 0;
          m_dn = 1; m_first = 1;
        end
      end else if (m_fl == 0 && m_dl == 0 && m_dn == 0) begin
        m_busy = 0;
        if (m_w != 0) m_sel = ~m_sel;
      end
      if (m_busy != 0) begin
        if (m_fl > 0) begin
          e_av = 1; e_addr = m_k / m_r; e_sub = m_k % m_r;
          if (m_first != 0 || !stall) begin
            e_en = 1; e_cin = (m_k == 0); m_k++; m_fl--; m_first = 0;
          end
        end else begin
          e_av = 0;
          if (m_dl > 0) m_dl--;
          else if (m_dn != 0) begin e_done = 1; m_dn = 0; end
        end
      end
      e_busy = (m_busy != 0);
    end
  end

  // Compare every cycle against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("en_a", en_a, e_en);
      chk("en_b", en_b, e_en);
      chk("cin_en", cin_en, e_cin);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("sel", sel, m_sel);
      if (e_av) begin
        chk("rdaddr", rdaddr, e_addr);
        chk("sub_idx", sub_idx, e_sub);
      end
    end
    if (done === 1'b1) n_done++;
  end

  // ---------------- stimulus ----------------
  logic obs_en [0:63];
  logic obs_cin[0:63];
  logic obs_bsy[0:63];
  int   obs_addr[0:63];
  int   obs_sub [0:63];

  // Pulse start, then record outputs per cycle (cycle 1 = after acceptance)
  // until done. stall_mask[e] is the stall level seen at edge e.
  task automatic run_tile(input int md, input int w, input logic [63:0] stall_mask,
                          input int glitch_edge, output int done_cyc);
    @(posedge clk); #2;
    mode = md[1:0]; words = w[AW:0]; start = 1'b1; stall = 1'b0;
    @(posedge clk); #2;
    start = 1'b0; stall = stall_mask[1];
    done_cyc = -1;
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      obs_en[c] = en_a; obs_cin[c] = cin_en; obs_bsy[c] = busy;
      obs_addr[c] = int'(rdaddr); obs_sub[c] = int'(sub_idx);
      if (done === 1'b1) begin done_cyc = c; break; end
      @(posedge clk); #2;
      stall = stall_mask[c+1]; start = (c + 1 == glitch_edge);
    end
    start = 1'b0; stall = 1'b0;
    chk("done_seen", done_cyc >= 0, 1);
  endtask

  task automatic idle_check(input logic exp_sel);
    @(posedge clk); #2;
    chk("idle_sel", sel, exp_sel);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int dc;
    int a2[4];
    int s2[4];
    a2 = '{0, 0, 1, 1};
    s2 = '{0, 1, 0, 1};
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en", en_a, 0); chk("rst_cin", cin_en, 0); chk("rst_addr", rdaddr, 0);
    chk("rst_sub", sub_idx, 0); chk("rst_sel", sel, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk_en = 1'b1;
    @(posedge clk); #2 rst = 1'b1;

    // FP32, 4 words
    run_tile(0, 4, 64'd0, 0, dc);
    chk("t1_done_cyc", dc, 12);
    for (int c = 1; c <= 4; c++) begin
      chk("t1_en", obs_en[c], 1); chk("t1_addr", obs_addr[c], c - 1);
      chk("t1_sub", obs_sub[c], 0); chk("t1_cin", obs_cin[c], (c == 1) ? 1 : 0);
    end
    for (int c = 5; c <= 11; c++) chk("t1_drain_en", obs_en[c], 0);
    idle_check(1'b1);

    // FP16, 2 words
    run_tile(1, 2, 64'd0, 0, dc);
    chk("t2_done_cyc", dc, 12);
    for (int c = 1; c <= 4; c++) begin
      chk("t2_addr", obs_addr[c], a2[c-1]); chk("t2_sub", obs_sub[c], s2[c-1]);
    end
    idle_check(1'b0);

    // INT4, 1 word, back-to-back pair
    run_tile(3, 1, 64'd0, 0, dc);
    chk("t3a_done_cyc", dc, 16);
    for (int c = 1; c <= 8; c++) begin
      chk("t3_addr", obs_addr[c], 0); chk("t3_sub", obs_sub[c], c - 1);
    end
    run_tile(3, 1, 64'd0, 0, dc);
    chk("t3b_done_cyc", dc, 16);
    idle_check(1'b0);

    // INT8, 2 words, stall over three cycles while (0,2) is pending
    run_tile(2, 2, 64'b11100, 0, dc);
    chk("t4_done_cyc", dc, 19);
    for (int c = 3; c <= 5; c++) begin
      chk("t4_stall_en", obs_en[c], 0); chk("t4_stall_addr", obs_addr[c], 0);
      chk("t4_stall_sub", obs_sub[c], 2);
    end
    chk("t4_resume_en", obs_en[6], 1); chk("t4_resume_sub", obs_sub[6], 2);
    chk("t4_last_addr", obs_addr[11], 1); chk("t4_last_sub", obs_sub[11], 3);
    idle_check(1'b1);

    // Empty tile
    run_tile(0, 0, 64'd0, 0, dc);
    chk("t5_done_cyc", dc, 1);
    chk("t5_en", obs_en[1], 0); chk("t5_busy", obs_bsy[1], 1);
    idle_check(1'b1);
    chk("done_count_a", n_done, 6);

    // Reset mid-FETCH while (1,0) is on the outputs
    @(posedge clk); #2 mode = 2'd2; words = 5'd3; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_pre_addr", rdaddr, 1); chk("t6_pre_sub", sub_idx, 0); chk("t6_pre_en", en_a, 1);
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_en", en_a, 0); chk("t6_rst_addr", rdaddr, 0); chk("t6_rst_sub", sub_idx, 0);
    chk("t6_rst_sel", sel, 0); chk("t6_rst_busy", busy, 0); chk("t6_rst_cin", cin_en, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    run_tile(0, 2, 64'd0, 0, dc);
    chk("t6_new_addr", obs_addr[1], 0); chk("t6_new_cin", obs_cin[1], 1);
    chk("t6_done_cyc", dc, 10);
    idle_check(1'b1);
    chk("done_count_b", n_done, 7);

    // start pulses inside FETCH and DRAIN are ignored
    run_tile(1, 2, 64'd0, 3, dc);
    chk("t7a_done_cyc", dc, 12);
    run_tile(1, 2, 64'd0, 8, dc);
    chk("t7b_done_cyc", dc, 12);
    repeat (20) @(posedge clk);
    #2 chk("done_count_c", n_done, 9);
    chk("t7_sel", sel, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
